// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with valid/ready input and an internal baud counter
module uart_tx_cfg #(
    parameter int DATA_W    = 8,
    parameter int BAUD_DIV  = 434,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(DATA_W);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shift;
    logic              par;
    logic              tc;
    logic              last_bit;
    logic              last_stop;
    assign tc        = cnt == CW'(BAUD_DIV - 1);
    assign last_bit  = idx == IW'(DATA_W - 1);
    assign last_stop = idx == IW'(STOP_BITS - 1);
    assign o_busy    = state != IDLE;
    assign o_ready   = ~o_busy;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            par    <= 1'b0;
            o_tx   <= 1'b1;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_tx   <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PAR ? par : 1'b1;
            if (state == IDLE) begin
                cnt <= '0;
                idx <= '0;
                if (i_valid) begin
                    state <= START;
                    shift <= i_data;
                    par   <= PARITY == 2 ? ~^i_data : ^i_data;
                end
            end else begin
                cnt <= tc ? '0 : cnt + 1'b1;
                if (tc) begin
                    case (state)
                        START: begin
                            state <= DATA;
                            idx   <= '0;
                        end
                        DATA: begin
                            shift <= shift >> 1;
                            idx   <= last_bit ? '0 : idx + 1'b1;
                            if (last_bit) state <= PARITY != 0 ? PAR : STOP;
                        end
                        PAR: begin
                            state <= STOP;
                            idx   <= '0;
                        end
                        default: begin
                            idx <= last_stop ? '0 : idx + 1'b1;
                            if (last_stop) begin
                                state  <= IDLE;
                                o_done <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench over five parameter sets of uart_tx_cfg
module tb_uart_tx_cfg;
    localparam int N = 5;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] vld = '0;
    logic [N-1:0] rdy, txo, bsy, dne;
    logic [8:0]   dat [N];
    int           acc [N] = '{default: 0};
    logic [8:0]   sb [$];
    int           n_vec = 0;
    int           n_err = 0;
    logic         cap_tx [100];
    logic         cap_done [100];
    logic         cap_rdy [100];
    logic         cap_bsy [100];

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .rst(rst), .i_valid(vld[0]),
        .i_data(dat[0][7:0]), .o_ready(rdy[0]), .o_tx(txo[0]), .o_busy(bsy[0]), .o_done(dne[0]));
    uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(1)) u1 (.clk(clk), .rst(rst), .i_valid(vld[1]),
        .i_data(dat[1][7:0]), .o_ready(rdy[1]), .o_tx(txo[1]), .o_busy(bsy[1]), .o_done(dne[1]));
    uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(1)) u2 (.clk(clk), .rst(rst), .i_valid(vld[2]),
        .i_data(dat[2][7:0]), .o_ready(rdy[2]), .o_tx(txo[2]), .o_busy(bsy[2]), .o_done(dne[2]));
    uart_tx_cfg #(.DATA_W(8), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .i_valid(vld[3]),
        .i_data(dat[3][7:0]), .o_ready(rdy[3]), .o_tx(txo[3]), .o_busy(bsy[3]), .o_done(dne[3]));
    uart_tx_cfg #(.DATA_W(5), .BAUD_DIV(2), .PARITY(0), .STOP_BITS(1)) u4 (.clk(clk), .rst(rst), .i_valid(vld[4]),
        .i_data(dat[4][4:0]), .o_ready(rdy[4]), .o_tx(txo[4]), .o_busy(bsy[4]), .o_done(dne[4]));

    always @(posedge clk)
        for (int k = 0; k < N; k++) if (vld[k] && rdy[k]) acc[k] <= acc[k] + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input int k, input logic [8:0] w);
        @(negedge clk);
        vld[k] = 1'b1;
        dat[k] = w;
        sb.push_back(w);
        @(posedge clk);
    endtask

    // cycle c of the capture is the c-th clock period after the accept edge
    task automatic capture(input int k, input int n, input int pulse);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            cap_tx[c]   = txo[k];
            cap_done[c] = dne[k];
            cap_rdy[c]  = rdy[k];
            cap_bsy[c]  = bsy[k];
            vld[k] = c == pulse;
            if (c == pulse) dat[k] = 9'h1ff;
        end
    endtask

    task automatic decode(input int s, input int dw, input int bd, input int np, input int ns,
                          output logic [8:0] w, output logic p, output int bad);
        logic v;
        w = '0;
        p = 1'b0;
        bad = 0;
        for (int i = 0; i < bd; i++) if (cap_tx[s+i] !== 1'b0) bad++;
        for (int b = 0; b < dw + np; b++) begin
            v = cap_tx[s+bd*(b+1)];
            for (int i = 1; i < bd; i++) if (cap_tx[s+bd*(b+1)+i] !== v) bad++;
            if (b < dw) w[b] = v;
            else p = v;
        end
        for (int i = 0; i < ns * bd; i++) if (cap_tx[s+bd*(1+dw+np)+i] !== 1'b1) bad++;
    endtask

    task automatic test_reset;
        for (int k = 0; k < N; k++) dat[k] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_vec++;
            if ({txo[k], rdy[k], bsy[k], dne[k]} !== 4'b1100) begin
                n_err++;
                $display("FAIL reset_state[%0d]: tx/ready/busy/done got %b, expected 1100", k, {txo[k], rdy[k], bsy[k], dne[k]});
            end
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (rdy !== '1 || txo !== '1 || bsy !== '0 || dne !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: ready %b tx %b busy %b done %b", rdy, txo, bsy, dne);
        end
    endtask

    task automatic test_basic(input logic [8:0] word, input string name);
        logic [8:0] w, e;
        logic p;
        int bad, nd, nr;
        send(0, word);
        capture(0, 44, 0);
        e = sb.pop_front();
        decode(2, 8, 4, 0, 1, w, p, bad);
        nd = 0;
        nr = 0;
        for (int c = 1; c <= 44; c++) begin
            if (cap_done[c] !== (c == 41)) nd++;
            if (cap_rdy[c] !== (c >= 41) || cap_bsy[c] !== (c < 41)) nr++;
        end
        n_vec++;
        if (cap_tx[1] !== 1'b1 || cap_tx[2] !== 1'b0) begin
            n_err++;
            $display("FAIL %s_latency: tx c1=%b c2=%b, expected 1 then 0", name, cap_tx[1], cap_tx[2]);
        end
        n_vec++;
        if (w[7:0] !== e[7:0]) begin
            n_err++;
            $display("FAIL %s_data: got %h, expected %h", name, w[7:0], e[7:0]);
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL %s_shape: %0d bad line cycles, expected 0", name, bad);
        end
        n_vec++;
        if (nd !== 0 || nr !== 0) begin
            n_err++;
            $display("FAIL %s_timing: %0d done and %0d ready/busy errors, expected 0", name, nd, nr);
        end
    endtask

    task automatic test_parity;
        int          ks [3] = '{1, 2, 1};
        logic [8:0]  ws [3] = '{9'h007, 9'h007, 9'h000};
        logic [8:0]  w, e;
        logic        p, ep;
        int          bad, nd;
        for (int t = 0; t < 3; t++) begin
            send(ks[t], ws[t]);
            capture(ks[t], 47, 0);
            e = sb.pop_front();
            ep = ks[t] == 2 ? ~^e[7:0] : ^e[7:0];
            decode(2, 8, 4, 1, 1, w, p, bad);
            nd = 0;
            for (int c = 1; c <= 47; c++) if (cap_done[c] !== (c == 45) || cap_rdy[c] !== (c >= 45)) nd++;
            n_vec++;
            if (p !== ep || w[7:0] !== e[7:0]) begin
                n_err++;
                $display("FAIL parity_%0d: data %h parity %b, expected %h parity %b", t, w[7:0], p, e[7:0], ep);
            end
            n_vec++;
            if (bad !== 0 || nd !== 0) begin
                n_err++;
                $display("FAIL parity_frame_%0d: %0d shape and %0d timing errors, expected 0", t, bad, nd);
            end
        end
    endtask

    task automatic test_stop2;
        logic [8:0] w, e;
        logic p;
        int bad, nd, hi;
        send(3, 9'h0ff);
        capture(3, 47, 0);
        e = sb.pop_front();
        decode(2, 8, 4, 0, 2, w, p, bad);
        nd = 0;
        hi = 0;
        for (int c = 1; c <= 47; c++) if (cap_done[c] !== (c == 45) || cap_rdy[c] !== (c >= 45)) nd++;
        for (int c = 38; c <= 45; c++) if (cap_tx[c] === 1'b1) hi++;
        n_vec++;
        if (w[7:0] !== e[7:0] || bad !== 0 || hi !== 8) begin
            n_err++;
            $display("FAIL stop2_frame: data %h, %0d shape errors, %0d stop cycles; expected %h, 0, 8", w[7:0], bad, hi, e[7:0]);
        end
        n_vec++;
        if (nd !== 0) begin
            n_err++;
            $display("FAIL stop2_done: %0d done/ready errors, expected 0 (done at 45)", nd);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] w1, w2, e1, e2;
        logic p;
        int bad1, bad2, nd, a0;
        a0 = acc[0];
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 9'h0a5;
        sb.push_back(9'h0a5);
        @(posedge clk);
        for (int c = 1; c <= 85; c++) begin
            @(negedge clk);
            cap_tx[c]   = txo[0];
            cap_done[c] = dne[0];
            if (c == 1) begin
                dat[0] = 9'h03c;
                sb.push_back(9'h03c);
            end
            if (c == 42) vld[0] = 1'b0;
        end
        e1 = sb.pop_front();
        e2 = sb.pop_front();
        decode(2, 8, 4, 0, 1, w1, p, bad1);
        decode(43, 8, 4, 0, 1, w2, p, bad2);
        nd = 0;
        for (int c = 1; c <= 85; c++) if (cap_done[c] !== (c == 41 || c == 82)) nd++;
        n_vec++;
        if (w1[7:0] !== e1[7:0] || w2[7:0] !== e2[7:0] || bad1 !== 0 || bad2 !== 0) begin
            n_err++;
            $display("FAIL b2b_data: got %h %h (%0d/%0d bad), expected %h %h", w1[7:0], w2[7:0], bad1, bad2, e1[7:0], e2[7:0]);
        end
        n_vec++;
        if (cap_tx[41] !== 1'b1 || cap_tx[42] !== 1'b1 || cap_tx[43] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: tx c41..43 = %b%b%b, expected 110", cap_tx[41], cap_tx[42], cap_tx[43]);
        end
        n_vec++;
        if (acc[0] - a0 !== 2 || nd !== 0) begin
            n_err++;
            $display("FAIL b2b_accepts: %0d accepts, %0d done errors; expected 2, 0", acc[0] - a0, nd);
        end
    endtask

    task automatic test_reset_midframe;
        logic [8:0] e;
        int nd;
        send(0, 9'h081);
        capture(0, 14, 0);
        e = sb.pop_front();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({txo[0], rdy[0], bsy[0]} !== 3'b110) begin
            n_err++;
            $display("FAIL abort_state: tx/ready/busy got %b, expected 110 (aborted %h)", {txo[0], rdy[0], bsy[0]}, e[7:0]);
        end
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dne[0] !== 1'b0) nd++;
            if (c == 3) rst = 1'b1;
        end
        n_vec++;
        if (nd !== 0) begin
            n_err++;
            $display("FAIL abort_done: %0d done pulses, expected 0", nd);
        end
        test_basic(9'h03c, "post_reset");
    endtask

    task automatic test_small;
        logic [8:0] w, e;
        logic p;
        int bad, nd, a0;
        a0 = acc[4];
        send(4, 9'h013);
        capture(4, 18, 5);
        e = sb.pop_front();
        decode(2, 5, 2, 0, 1, w, p, bad);
        nd = 0;
        for (int c = 1; c <= 18; c++) if (cap_done[c] !== (c == 15) || cap_rdy[c] !== (c >= 15)) nd++;
        n_vec++;
        if (w[4:0] !== e[4:0] || bad !== 0) begin
            n_err++;
            $display("FAIL small_data: got %h (%0d bad), expected %h", w[4:0], bad, e[4:0]);
        end
        n_vec++;
        if (nd !== 0 || acc[4] - a0 !== 1) begin
            n_err++;
            $display("FAIL small_timing: %0d done/ready errors, %0d accepts; expected 0, 1", nd, acc[4] - a0);
        end
    endtask

    initial begin
        test_reset;
        test_basic(9'h055, "basic");
        test_parity;
        test_stop2;
        test_back_to_back;
        test_reset_midframe;
        test_small;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
